// File: rtl/move_pulse_gen.sv
// move_pulse_gen: turns held left/right/falling levels into one-cycle move/drop pulses.
// Define MOVE_REPEAT_EN to build the DAS/ARR auto-repeat; without it only the initial press pulses.
module move_pulse_gen #(
    parameter int DAS_TICKS = 16,
    parameter int ARR_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic left,
    input  logic right,
    input  logic falling,
    output logic move_left,
    output logic move_right,
    output logic drop
);

    typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_t;

    dir_t dir;
    dir_t dir_q;
    logic fall_q;

    // Both keys held cancel each other out.
    always_comb begin
        dir = DIR_NONE;
        if (left && !right) begin
            dir = DIR_L;
        end else if (right && !left) begin
            dir = DIR_R;
        end
    end

`ifdef MOVE_REPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    localparam logic [7:0] DAS_LAST = 8'(DAS_TICKS - 1);
    localparam logic [7:0] ARR_LAST = 8'(ARR_TICKS - 1);

    state_t     state;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            dir_q      <= DIR_NONE;
            fall_q     <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            drop       <= 1'b0;
        end else begin
            dir_q      <= dir;
            fall_q     <= falling;
            drop       <= falling && !fall_q;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            if (dir == DIR_NONE) begin
                state <= IDLE;
                cnt   <= 8'd0;
            end else if (dir != dir_q) begin
                // A new direction swallows any tick arriving in the same cycle.
                move_left  <= (dir == DIR_L);
                move_right <= (dir == DIR_R);
                cnt        <= 8'd0;
                state      <= DELAY;
            end else if (tick) begin
                case (state)
                    DELAY: begin
                        if (cnt == DAS_LAST) begin
                            move_left  <= (dir == DIR_L);
                            move_right <= (dir == DIR_R);
                            cnt        <= 8'd0;
                            state      <= REPEAT;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    REPEAT: begin
                        if (cnt == ARR_LAST) begin
                            move_left  <= (dir == DIR_L);
                            move_right <= (dir == DIR_R);
                            cnt        <= 8'd0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`else
    // Tick and timing parameters have no role without auto-repeat.
    logic unused_cfg;
    assign unused_cfg = ^{tick, 8'(DAS_TICKS), 8'(ARR_TICKS)};

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q      <= DIR_NONE;
            fall_q     <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            drop       <= 1'b0;
        end else begin
            dir_q      <= dir;
            fall_q     <= falling;
            drop       <= falling && !fall_q;
            move_left  <= (dir == DIR_L) && (dir_q != DIR_L);
            move_right <= (dir == DIR_R) && (dir_q != DIR_R);
        end
    end
`endif

endmodule

// File: tb/tb_move_pulse_gen.sv
// Directed bench for move_pulse_gen: per-phase pulse bitmaps compared against hand-derived patterns.
module tb_move_pulse_gen;

    localparam int DAS = 3;
    localparam int ARR = 2;

`ifdef MOVE_REPEAT_EN
    localparam logic [63:0] E_HOLD40 = 64'h0000_0008_0808_0801;
    localparam logic [63:0] E_TICKC  = 64'h0000_0000_0010_1001;
    localparam logic [63:0] E_DAS1   = 64'h0000_0000_0000_0801;
`else
    localparam logic [63:0] E_HOLD40 = 64'h1;
    localparam logic [63:0] E_TICKC  = 64'h1;
    localparam logic [63:0] E_DAS1   = 64'h1;
`endif
    localparam logic [63:0] E_ONE  = 64'h1;
    localparam logic [63:0] E_NONE = 64'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic left = 1'b0;
    logic right = 1'b0;
    logic falling = 1'b0;
    logic move_left;
    logic move_right;
    logic drop;

    int tests = 0;
    int fails = 0;
    int both_hi = 0;

    move_pulse_gen #(
        .DAS_TICKS(DAS),
        .ARR_TICKS(ARR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .left(left),
        .right(right),
        .falling(falling),
        .move_left(move_left),
        .move_right(move_right),
        .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        $display("[TB] %s observed=%h expected=%h", tag, got, exp);
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Hold the given levels for n cycles; tick fires when (i+phase)%4==3.
    // Bit i of each bitmap is the output seen just after the edge sampling cycle i.
    task automatic hold(input string tag, input int n, input int phase,
                        input logic l, input logic r, input logic f,
                        input logic [63:0] exp_l, input logic [63:0] exp_r,
                        input logic [63:0] exp_d);
        logic [63:0] sl;
        logic [63:0] sr;
        logic [63:0] sd;
        sl = '0;
        sr = '0;
        sd = '0;
        left = l;
        right = r;
        falling = f;
        for (int i = 0; i < n; i++) begin
            tick = (((i + phase) % 4) == 3);
            @(posedge clk);
            #1;
            sl[i] = move_left;
            sr[i] = move_right;
            sd[i] = drop;
            if (move_left && move_right) both_hi++;
        end
        tick = 1'b0;
        check({tag, ".move_left"}, sl, exp_l);
        check({tag, ".move_right"}, sr, exp_r);
        check({tag, ".drop"}, sd, exp_d);
    endtask

    initial begin
        // Reset held with idle inputs.
        rst = 1'b1;
        hold("reset", 3, 0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE, E_NONE);
        rst = 1'b0;
        hold("first_press", 8, 0, 1'b1, 1'b0, 1'b0, E_ONE, E_NONE, E_NONE);
        hold("release0", 8, 0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE, E_NONE);

        // Long hold: immediate, DAS, then ARR cadence; release stops pulses.
        hold("hold40", 40, 0, 1'b1, 1'b0, 1'b0, E_HOLD40, E_NONE, E_NONE);
        hold("release1", 12, 0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE, E_NONE);

        // Tick coinciding with the press must not advance the counter.
        hold("tick_on_press", 24, 3, 1'b1, 1'b0, 1'b0, E_TICKC, E_NONE, E_NONE);
        hold("release2", 4, 0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE, E_NONE);

        // Both keys cancel; releasing one gives an immediate move the other way.
        hold("left12", 12, 0, 1'b1, 1'b0, 1'b0, E_DAS1, E_NONE, E_NONE);
        hold("both_a", 12, 0, 1'b1, 1'b1, 1'b0, E_NONE, E_NONE, E_NONE);
        hold("left_again", 8, 0, 1'b1, 1'b0, 1'b0, E_ONE, E_NONE, E_NONE);
        hold("both_b", 4, 0, 1'b1, 1'b1, 1'b0, E_NONE, E_NONE, E_NONE);
        hold("right_after_both", 16, 0, 1'b0, 1'b1, 1'b0, E_NONE, E_DAS1, E_NONE);
        hold("right_to_left", 4, 0, 1'b1, 1'b0, 1'b0, E_ONE, E_NONE, E_NONE);
        hold("release3", 4, 0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE, E_NONE);

        // Drop is edge-triggered only, and may coincide with a move.
        hold("fall20", 20, 0, 1'b0, 1'b0, 1'b1, E_NONE, E_NONE, E_ONE);
        hold("release4", 4, 0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE, E_NONE);
        hold("fall_again", 6, 0, 1'b0, 1'b0, 1'b1, E_NONE, E_NONE, E_ONE);
        hold("release5", 4, 0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE, E_NONE);
        hold("fall_and_right", 8, 0, 1'b0, 1'b1, 1'b1, E_NONE, E_ONE, E_ONE);
        hold("release6", 4, 0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE, E_NONE);

        // Reset mid-repeat with right still held: fresh press afterwards.
        hold("right16", 16, 0, 1'b0, 1'b1, 1'b0, E_NONE, E_DAS1, E_NONE);
        rst = 1'b1;
        hold("reset_mid", 3, 0, 1'b0, 1'b1, 1'b0, E_NONE, E_NONE, E_NONE);
        rst = 1'b0;
        hold("after_reset", 16, 0, 1'b0, 1'b1, 1'b0, E_NONE, E_DAS1, E_NONE);
        hold("release7", 4, 0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE, E_NONE);

        tests++;
        assert (both_hi === 0) else begin
            fails++;
            $error("FAIL exclusive_moves: observed %0d overlaps expected 0", both_hi);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
